// File: rtl/led_sweep_pkg.sv
// ----------------------------------------------------------------------------
// led_sweep_pkg
// Shared definitions for the LED sweep block.
//   state_t      : FSM state encoding (IDLE, RUN_UP, RUN_DOWN)
//   MODE_*       : encodings of the 2-bit i_mode input
// ----------------------------------------------------------------------------
package led_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN_UP   = 2'd1,
        RUN_DOWN = 2'd2
    } state_t;

    localparam logic [1:0] MODE_BOUNCE = 2'd0;
    localparam logic [1:0] MODE_ROT_L  = 2'd1;
    localparam logic [1:0] MODE_ROT_R  = 2'd2;
    localparam logic [1:0] MODE_OFF    = 2'd3;

endpackage

// File: rtl/led_sweep_tick.sv
// ----------------------------------------------------------------------------
// tick_gen
// Prescaler that counts enabled clock cycles 0..DIV-1 and raises o_tick
// (combinationally) in the cycle the count sits at DIV-1 while enabled.
//   i_clk    : clock, rising edge
//   i_rst_n  : asynchronous active-low reset
//   i_enable : count advances only when high, otherwise held
//   i_clear  : synchronous clear to 0, overrides i_enable
//   o_tick   : one-cycle step strobe
// ----------------------------------------------------------------------------
module tick_gen #(
    parameter int DIV = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_enable,
    input  logic i_clear,
    output logic o_tick
);

    // A one-bit counter is kept for DIV=1 so the register is never zero width;
    // it simply stays at 0 and every enabled cycle is a tick.
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    assign o_tick = i_enable && (count == LAST);

    // Counter register: clear wins over enable, and the count wraps to 0 in
    // the same cycle the tick is issued.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count <= '0;
        end else if (i_clear) begin
            count <= '0;
        end else if (i_enable) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/led_sweep.sv
// ----------------------------------------------------------------------------
// led_sweep
// Drives a single lit LED that bounces or rotates across WIDTH outputs,
// stepping once every DIV enabled clock cycles.
//   i_clk    : clock, rising edge
//   i_rst_n  : asynchronous active-low reset
//   i_enable : advances the prescaler and pattern when high, freezes when low
//   i_mode   : 0 bounce, 1 rotate left, 2 rotate right, 3 off
//   o_led    : registered one-hot (or all-zero) LED pattern
//   o_wrap   : registered one-cycle pulse at the end of each pattern period
// ----------------------------------------------------------------------------
module led_sweep
    import led_sweep_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV   = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic [1:0]       i_mode,
    output logic [WIDTH-1:0] o_led,
    output logic             o_wrap
);

    localparam int PW = $clog2(WIDTH);
    localparam logic [PW-1:0] POS_MAX = PW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] LED_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t          state, state_n;
    logic [PW-1:0]   pos, pos_n;
    logic            wrap_n;
    logic [WIDTH-1:0] led_n;
    logic            tick;
    logic            mode_off;
    logic            go_up;

    assign mode_off = (i_mode == MODE_OFF);

    tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_enable (i_enable),
        .i_clear  (mode_off),
        .o_tick   (tick)
    );

    // Bounce direction: the two ends force the direction, anywhere in between
    // the current run state decides. This also covers switching into bounce
    // from a rotate mode without restarting the sweep.
    always_comb begin
        go_up = (state == RUN_UP);
        if (pos == '0) begin
            go_up = 1'b1;
        end else if (pos == POS_MAX) begin
            go_up = 1'b0;
        end
    end

    // Next-state logic. Mode "off" overrides everything, including a frozen
    // (disabled) prescaler. Otherwise nothing moves unless a tick is present,
    // which is what keeps state, pos and o_led frozen while i_enable is low.
    always_comb begin
        state_n = state;
        pos_n   = pos;
        wrap_n  = 1'b0;
        if (mode_off) begin
            state_n = IDLE;
            pos_n   = '0;
        end else if (tick) begin
            if (state == IDLE) begin
                if (i_mode == MODE_ROT_R) begin
                    state_n = RUN_DOWN;
                    pos_n   = POS_MAX;
                end else begin
                    state_n = RUN_UP;
                    pos_n   = '0;
                end
            end else begin
                case (i_mode)
                    MODE_BOUNCE: begin
                        if (go_up) begin
                            state_n = RUN_UP;
                            pos_n   = pos + PW'(1);
                        end else begin
                            state_n = RUN_DOWN;
                            pos_n   = pos - PW'(1);
                            wrap_n  = (pos == PW'(1));
                        end
                    end
                    MODE_ROT_L: begin
                        state_n = RUN_UP;
                        if (pos == POS_MAX) begin
                            pos_n  = '0;
                            wrap_n = 1'b1;
                        end else begin
                            pos_n = pos + PW'(1);
                        end
                    end
                    MODE_ROT_R: begin
                        state_n = RUN_DOWN;
                        if (pos == '0) begin
                            pos_n  = POS_MAX;
                            wrap_n = 1'b1;
                        end else begin
                            pos_n = pos - PW'(1);
                        end
                    end
                    default: begin
                        state_n = state;
                    end
                endcase
            end
        end
    end

    // The LED pattern is decoded from the next state so that o_led changes on
    // the same edge as the position it represents.
    always_comb begin
        led_n = '0;
        if (state_n != IDLE) begin
            led_n = LED_ONE << pos_n;
        end
    end

    // State, position and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            pos    <= '0;
            o_led  <= '0;
            o_wrap <= 1'b0;
        end else begin
            state  <= state_n;
            pos    <= pos_n;
            o_led  <= led_n;
            o_wrap <= wrap_n;
        end
    end

endmodule

// File: tb/tb_led_sweep.sv
// ----------------------------------------------------------------------------
// tb_led_sweep
// Directed bench for led_sweep. Three instances share one set of inputs:
//   dut8 : WIDTH=8, DIV=1
//   dut4 : WIDTH=8, DIV=4
//   dut2 : WIDTH=2, DIV=1
// ----------------------------------------------------------------------------
module tb_led_sweep;

    logic       i_clk    = 1'b0;
    logic       i_rst_n  = 1'b0;
    logic       i_enable = 1'b0;
    logic [1:0] i_mode   = 2'd0;

    logic [7:0] led8, led4;
    logic [1:0] led2;
    logic       wrap8, wrap4, wrap2;

    int checks = 0;
    int errors = 0;

    logic [7:0] bounce_seq [16];
    logic [7:0] rotr_seq [4];

    always #5 i_clk = ~i_clk;

    led_sweep #(.WIDTH(8), .DIV(1)) dut8 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(i_enable),
        .i_mode(i_mode), .o_led(led8), .o_wrap(wrap8)
    );

    led_sweep #(.WIDTH(8), .DIV(4)) dut4 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(i_enable),
        .i_mode(i_mode), .o_led(led4), .o_wrap(wrap4)
    );

    led_sweep #(.WIDTH(2), .DIV(1)) dut2 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(i_enable),
        .i_mode(i_mode), .o_led(led2), .o_wrap(wrap2)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Drive inputs for one clock, then land 1 time unit after the edge.
    task automatic applyStimulus(input logic en, input logic [1:0] mode);
        i_enable = en;
        i_mode   = mode;
        @(posedge i_clk);
        #1;
    endtask

    task automatic resetDut();
        i_enable = 1'b0;
        i_mode   = 2'd0;
        i_rst_n  = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst_n  = 1'b1;
    endtask

    initial begin
        bounce_seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                       8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
        rotr_seq   = '{8'h04, 8'h02, 8'h01, 8'h80};

        // Reset state
        resetDut();
        checkOutput("reset led8", {24'd0, led8}, 32'h00);
        checkOutput("reset wrap8", {31'd0, wrap8}, 32'h0);
        checkOutput("reset led4", {24'd0, led4}, 32'h00);
        checkOutput("reset led2", {30'd0, led2}, 32'h0);

        // Bounce on all three instances
        $display("[TB] bounce sequence");
        for (int i = 0; i < 16; i++) begin
            int k;
            applyStimulus(1'b1, 2'd0);
            checkOutput($sformatf("bounce led8[%0d]", i), {24'd0, led8}, {24'd0, bounce_seq[i]});
            checkOutput($sformatf("bounce wrap8[%0d]", i), {31'd0, wrap8}, (i == 14) ? 32'd1 : 32'd0);
            checkOutput($sformatf("w2 led[%0d]", i), {30'd0, led2}, (i % 2 == 0) ? 32'd1 : 32'd2);
            checkOutput($sformatf("w2 wrap[%0d]", i), {31'd0, wrap2},
                        ((i % 2 == 0) && (i > 0)) ? 32'd1 : 32'd0);
            k = (i + 1) / 4;
            checkOutput($sformatf("div4 led[%0d]", i), {24'd0, led4}, (k == 0) ? 32'd0 : (32'd1 << (k - 1)));
            checkOutput($sformatf("div4 wrap[%0d]", i), {31'd0, wrap4}, 32'd0);
        end

        // Rotate left, then switch to rotate right at 08
        $display("[TB] rotate sequence");
        resetDut();
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 2'd1);
            checkOutput($sformatf("rotl led[%0d]", i), {24'd0, led8}, 32'd1 << (i % 8));
            checkOutput($sformatf("rotl wrap[%0d]", i), {31'd0, wrap8}, (i == 8) ? 32'd1 : 32'd0);
        end
        for (int j = 0; j < 4; j++) begin
            applyStimulus(1'b1, 2'd2);
            checkOutput($sformatf("rotr led[%0d]", j), {24'd0, led8}, {24'd0, rotr_seq[j]});
            checkOutput($sformatf("rotr wrap[%0d]", j), {31'd0, wrap8}, (j == 3) ? 32'd1 : 32'd0);
        end

        // Prescaler DIV=4 with an enable gap of 3 cycles
        $display("[TB] prescaler and enable gap");
        resetDut();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 2'd0);
            checkOutput($sformatf("gap pre led4[%0d]", i), {24'd0, led4}, (i == 3) ? 32'h01 : 32'h00);
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 2'd0);
            checkOutput($sformatf("gap run led4[%0d]", i), {24'd0, led4}, 32'h01);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 2'd0);
            checkOutput($sformatf("gap hold led4[%0d]", i), {24'd0, led4}, 32'h01);
            checkOutput($sformatf("gap hold led8[%0d]", i), {24'd0, led8}, 32'h20);
            checkOutput($sformatf("gap hold wrap8[%0d]", i), {31'd0, wrap8}, 32'd0);
        end
        applyStimulus(1'b1, 2'd0);
        checkOutput("gap late led4", {24'd0, led4}, 32'h01);
        applyStimulus(1'b1, 2'd0);
        checkOutput("gap step led4", {24'd0, led4}, 32'h02);

        // Mode off from RUN_DOWN at 20, then restart
        $display("[TB] mode off");
        resetDut();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 2'd0);
        end
        checkOutput("off pre led8", {24'd0, led8}, 32'h20);
        applyStimulus(1'b1, 2'd3);
        checkOutput("off led8", {24'd0, led8}, 32'h00);
        applyStimulus(1'b1, 2'd0);
        checkOutput("off restart led8", {24'd0, led8}, 32'h01);
        checkOutput("off restart wrap8", {31'd0, wrap8}, 32'd0);
        applyStimulus(1'b0, 2'd3);
        checkOutput("off disabled led8", {24'd0, led8}, 32'h00);
        applyStimulus(1'b1, 2'd2);
        checkOutput("rotr entry led8", {24'd0, led8}, 32'h80);
        checkOutput("rotr entry wrap8", {31'd0, wrap8}, 32'd0);

        // Asynchronous reset mid-cycle at 10
        $display("[TB] async reset");
        resetDut();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 2'd0);
        end
        checkOutput("areset pre led8", {24'd0, led8}, 32'h10);
        #2;
        i_rst_n = 1'b0;
        #1;
        checkOutput("areset led8", {24'd0, led8}, 32'h00);
        checkOutput("areset wrap8", {31'd0, wrap8}, 32'd0);
        @(posedge i_clk);
        #1;
        checkOutput("areset hold led8", {24'd0, led8}, 32'h00);
        i_rst_n = 1'b1;
        applyStimulus(1'b1, 2'd0);
        checkOutput("areset first led8", {24'd0, led8}, 32'h01);
        checkOutput("areset first wrap8", {31'd0, wrap8}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_sweep.md
LED_SWEEP -- requirements
Module: led_sweep

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the number of LED outputs (legal range 2..32).
REQ-002 The module SHALL have parameter DIV, default 1, giving clock cycles per pattern step (legal range 1..2^24).
REQ-003 The module SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port i_enable, input, 1 bit: advances the prescaler and pattern when high; freezes both when low.
REQ-006 The module SHALL have port i_mode, input, 2 bits: 0 = bounce, 1 = rotate left (LSB->MSB), 2 = rotate right (MSB->LSB), 3 = off.
REQ-007 The module SHALL have port o_led, output, WIDTH bits: registered, one-hot or all-zero LED pattern.
REQ-008 The module SHALL have port o_wrap, output, 1 bit: registered one-cycle pulse marking completion of a full pattern period.

Function
REQ-009 A prescaler counting 0..DIV-1 SHALL issue a tick in the cycle it equals DIV-1 with i_enable high, then wrap to 0; DIV=1 SHALL tick every enabled cycle.
REQ-010 i_enable low SHALL hold the prescaler, position, state and o_led unchanged, and o_wrap SHALL be 0.
REQ-011 The FSM SHALL have states IDLE, RUN_UP and RUN_DOWN, plus a position register pos of width clog2(WIDTH).
REQ-012 In IDLE, o_led SHALL be 0; in RUN_UP and RUN_DOWN, o_led SHALL equal 1 << pos.
REQ-013 In any state, i_mode=3 SHALL force IDLE, pos=0, prescaler=0 and o_led=0 on the next clock edge, regardless of tick or i_enable.
REQ-014 On a tick in IDLE with i_mode 0 or 1, the FSM SHALL go to RUN_UP with pos=0; with i_mode 2, to RUN_DOWN with pos=WIDTH-1.
REQ-015 Bounce, RUN_UP: a tick SHALL increment pos; at pos=WIDTH-1 it SHALL instead go to RUN_DOWN with pos=WIDTH-2.
REQ-016 Bounce, RUN_DOWN: a tick SHALL decrement pos; at pos=0 it SHALL instead go to RUN_UP with pos=1. The period is 2*WIDTH-2 ticks.
REQ-017 Rotate left: a tick SHALL set state RUN_UP and pos=(pos+1) mod WIDTH.
REQ-018 Rotate right: a tick SHALL set state RUN_DOWN and pos=(pos-1) mod WIDTH.
REQ-019 A mode change between 0, 1 and 2 SHALL take effect at the next tick, starting from the current pos with no restart.
REQ-020 On entering bounce with pos=0, direction SHALL be up; with pos=WIDTH-1, down; otherwise the current state's direction SHALL be kept.
REQ-021 o_wrap SHALL pulse, aligned with the o_led update, on these tick transitions: bounce pos 1->0; rotate left WIDTH-1->0; rotate right 0->WIDTH-1.
REQ-022 o_wrap SHALL NOT pulse on the IDLE->RUN entry tick.
REQ-023 Step latency SHALL be one clock from the tick cycle to the o_led change.

Reset
REQ-024 Asserting i_rst_n low SHALL, without waiting for a clock edge, set state=IDLE, pos=0, prescaler=0, o_led=0 and o_wrap=0.
REQ-025 After i_rst_n deasserts, the first tick SHALL occur DIV enabled cycles later, per REQ-009 and REQ-014.

Structure
REQ-026 State encodings (IDLE, RUN_UP, RUN_DOWN) and mode constants (MODE_BOUNCE, MODE_ROT_L, MODE_ROT_R, MODE_OFF) SHALL live in package led_sweep_pkg.
REQ-027 The prescaler SHALL be a sub-module, tick_gen (parameter DIV; ports i_clk, i_rst_n, i_enable, i_clear, o_tick).
REQ-028 The design SHALL be sized for 120-400 lines of RTL.

Verification (WIDTH=8 unless stated)
REQ-029 Scenario: DIV=1, reset, mode 0, enable -> o_led 00,01,02,04..80,40..02,01; o_wrap high only with the second 01; period 14 ticks.
REQ-030 Scenario: DIV=1, mode 1 -> 01..80,01 with o_wrap on 80->01; switch to mode 2 at 08 -> 04,02,01,80 with o_wrap on 01->80.
REQ-031 Scenario: DIV=4 -> o_led changes exactly every 4th cycle; i_enable low for 3 cycles mid-count delays the next step by 3.
REQ-032 Scenario: bounce RUN_DOWN at 20, switch to mode 3 -> o_led=00 next edge; return to mode 0 -> next tick gives 01.
REQ-033 Scenario: assert i_rst_n low mid-cycle at o_led=10 -> o_led=00 before the next i_clk edge; no o_wrap pulse.
REQ-034 Scenario: WIDTH=2, mode 0 -> o_led 01,02,01,02 with o_wrap on each 02->01.
